mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the CPU's two memory ports:
//  port1 (instruction fetch, read-only) and port2 (load/store, read/write).
//  Each cycle, at most one port is granted the RAM. Load/store has priority;
//  a starvation guard bounds how long fetch can be locked out.
//  Read data is routed back to its owner through a latency-matched tag pipe.
//  Sits between cpu (port1/port2) and the RAM macro; cpu stalls on !gnt.
// PARAMETERS
//  AW            16  address width
//  DW            16  data width
//  RD_LAT        1   RAM read latency in cycles (legal 1..3)
//  STARVE_LIMIT  4   consecutive ldst grants allowed while pc waits (1..15)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset
//  i_pc_rd        in   1   fetch read request, held until o_pc_gnt
//  i_pc_addr      in   AW  fetch address
//  o_pc_gnt       out  1   fetch granted this cycle (comb)
//  o_pc_valid     out  1   one-cycle pulse: o_pc_rddata updated
//  o_pc_rddata    out  DW  fetch read data, held until next o_pc_valid
//  i_ldst_rd      in   1   load request, held until o_ldst_gnt
//  i_ldst_wr      in   1   store request, held until o_ldst_gnt
//  i_ldst_addr    in   AW  load/store address
//  i_ldst_wrdata  in   DW  store data
//  o_ldst_gnt     out  1   ldst granted this cycle (comb)
//  o_ldst_valid   out  1   one-cycle pulse: o_ldst_rddata updated (loads only)
//  o_ldst_rddata  out  DW  load data, held until next o_ldst_valid
//  o_mem_addr     out  AW  RAM address (comb mux of granted port)
//  o_mem_rd       out  1   RAM read strobe
//  o_mem_wr       out  1   RAM write strobe
//  o_mem_wrdata   out  DW  RAM write data (= i_ldst_wrdata)
//  i_mem_rddata   in   DW  RAM read data, valid RD_LAT cycles after o_mem_rd
//  o_proto_err    out  1   sticky: i_ldst_rd & i_ldst_wr seen together
// BEHAVIOUR
//  Reset (reset=0): all regs cleared; gnt, mem_rd/wr, valid, rddata, err = 0;
//   gnt/mem strobes forced 0 combinationally while reset is low.
//  Grant (comb, same cycle as request):
//   - ldst_req = i_ldst_rd|i_ldst_wr. Only ldst_req -> ldst; only pc_rd -> pc.
//   - both: ldst, unless starve_cnt==STARVE_LIMIT -> pc.
//   - at most one gnt per cycle; no request -> mem_rd=mem_wr=0, addr=0.
//  Starvation counter starve_cnt (4b): +1 when ldst granted while i_pc_rd=1;
//   cleared when pc granted or i_pc_rd=0; saturates at STARVE_LIMIT.
//  ldst rd&wr together: treated as write (no read issued), o_proto_err set
//   until reset.
//  Read return: tag pipe of RD_LAT stages {vld, owner}; entry pushed on every
//   granted read. At stage RD_LAT, i_mem_rddata is captured into the owner's
//   rddata reg and that port's valid pulses the NEXT cycle, i.e. read granted
//   in cycle T -> valid/rddata visible in cycle T+RD_LAT+1. Pipelined: one
//   read per cycle sustained, returns in grant order.
//  Writes: o_mem_wr in grant cycle only; no valid pulse; a read granted the
//   cycle after a write to the same address returns the new data (RAM order).
//  Non-owner rddata reg is never modified by another port's return.
//  Reset mid-operation clears tag pipe: in-flight reads are dropped, no valid.
// TESTING
//  1 pc_rd only, addr 0x0010, RAM[0x10]=0xBEEF -> gnt cycle T, o_pc_valid
//    at T+RD_LAT+1 with o_pc_rddata=0xBEEF, ldst_valid stays 0.
//  2 pc_rd and ldst_rd held 10 cycles, STARVE_LIMIT=4 -> grant pattern
//    L,L,L,L,P,L,L,L,L,P; each data returns to the correct port in order.
//  3 ldst_wr 0x0020<=0x1234, then ldst_rd 0x0020 next cycle -> o_ldst_rddata
//    =0x1234; o_mem_wr high exactly one cycle.
//  4 back-to-back pc reads 0x0..0x7 every cycle -> 8 valids on consecutive
//    cycles, data in address order, no bubbles.
//  5 ldst_rd=ldst_wr=1 at 0x0030 data 0x5555 -> write performed, no valid,
//    o_proto_err=1 and stays 1 until reset.
//  6 assert reset low with 2 reads in flight -> no valid pulses, all
//    outputs 0; after release, new read returns normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch (pc) and load/store (ldst).
// Load/store wins by default; a saturating counter lets fetch through after STARVE_LIMIT lockouts.
module mem_port_arbiter #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_pc_rd,
  input  logic [AW-1:0] i_pc_addr,
  output logic          o_pc_gnt,
  output logic          o_pc_valid,
  output logic [DW-1:0] o_pc_rddata,
  input  logic          i_ldst_rd,
  input  logic          i_ldst_wr,
  input  logic [AW-1:0] i_ldst_addr,
  input  logic [DW-1:0] i_ldst_wrdata,
  output logic          o_ldst_gnt,
  output logic          o_ldst_valid,
  output logic [DW-1:0] o_ldst_rddata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic [DW-1:0] i_mem_rddata,
  output logic          o_proto_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic              w_ldst_req;
  logic              w_starved;
  logic              w_pc_gnt;
  logic              w_ldst_gnt;
  logic              w_ret_pc;
  logic              w_ret_ldst;
  logic [3:0]        r_starve_cnt;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_own;
  logic              r_pc_valid;
  logic              r_ldst_valid;
  logic [DW-1:0]     r_pc_rddata;
  logic [DW-1:0]     r_ldst_rddata;
  logic              r_proto_err;

  assign w_ldst_req = i_ldst_rd | i_ldst_wr;
  assign w_starved  = (r_starve_cnt == LIMIT);

  // Grant decision; both grants are held low while reset is asserted
  always_comb begin
    w_pc_gnt   = 1'b0;
    w_ldst_gnt = 1'b0;
    if (!reset) begin
      w_pc_gnt   = 1'b0;
      w_ldst_gnt = 1'b0;
    end else if (i_pc_rd && (!w_ldst_req || w_starved)) begin
      w_pc_gnt = 1'b1;
    end else if (w_ldst_req) begin
      w_ldst_gnt = 1'b1;
    end else begin
      w_pc_gnt   = 1'b0;
      w_ldst_gnt = 1'b0;
    end
  end

  // RAM command mux; a load/store carrying both rd and wr is issued as a write only
  always_comb begin
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_mem_addr = '0;
    if (w_pc_gnt) begin
      o_mem_rd   = 1'b1;
      o_mem_addr = i_pc_addr;
    end else if (w_ldst_gnt) begin
      o_mem_wr   = i_ldst_wr;
      o_mem_rd   = ~i_ldst_wr;
      o_mem_addr = i_ldst_addr;
    end else begin
      o_mem_rd   = 1'b0;
      o_mem_wr   = 1'b0;
      o_mem_addr = '0;
    end
  end

  assign o_pc_gnt     = w_pc_gnt;
  assign o_ldst_gnt   = w_ldst_gnt;
  assign o_mem_wrdata = i_ldst_wrdata;

  // Counts consecutive ldst grants that kept a waiting fetch out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!i_pc_rd || w_pc_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_ldst_gnt && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  // Tag pipe tracking the owner of each issued read (own=1 means ldst)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= o_mem_rd;
      r_tag_own[0] <= w_ldst_gnt;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign w_ret_pc   = r_tag_vld[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
  assign w_ret_ldst = r_tag_vld[RD_LAT-1] &  r_tag_own[RD_LAT-1];

  // Capture returning RAM data into the owning port and pulse its valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_valid    <= 1'b0;
      r_ldst_valid  <= 1'b0;
      r_pc_rddata   <= '0;
      r_ldst_rddata <= '0;
    end else begin
      r_pc_valid   <= w_ret_pc;
      r_ldst_valid <= w_ret_ldst;
      if (w_ret_pc) begin
        r_pc_rddata <= i_mem_rddata;
      end
      if (w_ret_ldst) begin
        r_ldst_rddata <= i_mem_rddata;
      end
    end
  end

  // Sticky flag for a simultaneous load and store request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= r_proto_err | (i_ldst_rd & i_ldst_wr);
    end
  end

  assign o_pc_valid    = r_pc_valid;
  assign o_ldst_valid  = r_ldst_valid;
  assign o_pc_rddata   = r_pc_rddata;
  assign o_ldst_rddata = r_ldst_rddata;
  assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM plus a queue-based model of grants and read returns.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RD_LAT = 1;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic i_pc_rd = 1'b0, i_ldst_rd = 1'b0, i_ldst_wr = 1'b0;
  logic [AW-1:0] i_pc_addr = '0, i_ldst_addr = '0;
  logic [DW-1:0] i_ldst_wrdata = '0, i_mem_rddata;
  logic o_pc_gnt, o_pc_valid, o_ldst_gnt, o_ldst_valid, o_mem_rd, o_mem_wr, o_proto_err;
  logic [DW-1:0] o_pc_rddata, o_ldst_rddata, o_mem_wrdata;
  logic [AW-1:0] o_mem_addr;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_pc_rd(i_pc_rd), .i_pc_addr(i_pc_addr), .o_pc_gnt(o_pc_gnt),
    .o_pc_valid(o_pc_valid), .o_pc_rddata(o_pc_rddata),
    .i_ldst_rd(i_ldst_rd), .i_ldst_wr(i_ldst_wr), .i_ldst_addr(i_ldst_addr),
    .i_ldst_wrdata(i_ldst_wrdata), .o_ldst_gnt(o_ldst_gnt),
    .o_ldst_valid(o_ldst_valid), .o_ldst_rddata(o_ldst_rddata),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  // RAM macro: data appears RD_LAT cycles after the read strobe
  logic [DW-1:0] ram [0:65535];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= ram[o_mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (o_mem_wr) ram[o_mem_addr] = o_mem_wrdata;
  end
  assign i_mem_rddata = rd_pipe[RD_LAT-1];

  // Reference model state
  typedef struct { int due; bit own; logic [DW-1:0] d; } ret_t;
  ret_t q[$];
  logic [DW-1:0] m_mem [0:65535];
  int n_chk = 0, n_pass = 0, cyc = 0, m_wait = 0;
  logic m_err = 1'b0;
  logic e_pg, e_lg, e_mr, e_mw, e_pv, e_lv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] m_pc_d = '0, m_l_d = '0;

  task automatic drive(input logic prd, input logic [AW-1:0] pa, input logic lrd, input logic lwr,
                       input logic [AW-1:0] la, input logic [DW-1:0] wd);
    ret_t r;
    i_pc_rd = prd; i_pc_addr = pa; i_ldst_rd = lrd; i_ldst_wr = lwr;
    i_ldst_addr = la; i_ldst_wrdata = wd;
    #1;
    e_pg = prd && (!(lrd || lwr) || m_wait >= LIMIT);
    e_lg = (lrd || lwr) && !e_pg;
    e_mr = e_pg || (e_lg && !lwr);
    e_mw = e_lg && lwr;
    e_addr = e_pg ? pa : (e_lg ? la : 16'h0000);
    e_pv = 1'b0; e_lv = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.own) begin e_lv = 1'b1; m_l_d = r.d; end
      else begin e_pv = 1'b1; m_pc_d = r.d; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_pg) q.push_back('{cyc + RD_LAT + 1, 1'b0, m_mem[i_pc_addr]});
    if (e_mw) m_mem[i_ldst_addr] = i_ldst_wrdata;
    else if (e_lg) q.push_back('{cyc + RD_LAT + 1, 1'b1, m_mem[i_ldst_addr]});
    if (!i_pc_rd || e_pg) m_wait = 0;
    else if (e_lg && m_wait < LIMIT) m_wait++;
    if (i_ldst_rd && i_ldst_wr) m_err = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_pc_rd = 1'b1; i_ldst_rd = 1'b1; i_pc_addr = 16'h0004;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err,
         o_pc_rddata, o_ldst_rddata} !== '0)
      $display("FAIL reset_outputs got gnt=%b%b rd=%b wr=%b v=%b%b err=%b data=%h/%h required all 0",
               o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err,
               o_pc_rddata, o_ldst_rddata);
    else n_pass++;
    i_pc_rd = 1'b0; i_ldst_rd = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pc_single();
    ram[16'h0010] = 16'hBEEF; m_mem[16'h0010] = 16'hBEEF;
    for (int k = 0; k < RD_LAT + 4; k++) begin
      drive(k == 0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_mem_addr}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, e_addr})
        $display("FAIL pc_single_ctl cyc=%0d got=%b_%h required=%b_%h", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_mem_addr,
                 {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, e_addr);
      else n_pass++;
      if (k == RD_LAT + 1) begin
        n_chk++;
        if (o_pc_valid !== 1'b1 || o_pc_rddata !== 16'hBEEF)
          $display("FAIL pc_single_data got v=%b d=%h required v=1 d=beef", o_pc_valid, o_pc_rddata);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_starve();
    logic [9:0] pat;
    for (int k = 0; k < 10 + RD_LAT + 2; k++) begin
      drive(k < 10, 16'(16'h0100 + k), k < 10, 1'b0, 16'(16'h0200 + k), 16'h0000);
      if (k < 10) pat[k] = o_pc_gnt;
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_mem_addr}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, e_addr})
        $display("FAIL starve_ctl cyc=%0d got=%b_%h required=%b_%h", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_mem_addr,
                 {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, e_addr);
      else n_pass++;
      n_chk++;
      if ({o_pc_rddata, o_ldst_rddata} !== {m_pc_d, m_l_d})
        $display("FAIL starve_data cyc=%0d got=%h/%h required=%h/%h", k, o_pc_rddata, o_ldst_rddata, m_pc_d, m_l_d);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (pat !== 10'b1000010000)
      $display("FAIL starve_pattern got pc_gnt=%b required=%b", pat, 10'b1000010000);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int wr_cnt = 0;
    for (int k = 0; k < RD_LAT + 5; k++) begin
      drive(1'b0, 16'h0000, k == 1, k == 0, 16'h0020, 16'h1234);
      wr_cnt += int'(o_mem_wr);
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_mem_addr, o_mem_wrdata}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, e_addr, 16'h1234})
        $display("FAIL wr_rd_ctl cyc=%0d got=%b_%h_%h required=%b_%h_1234", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_mem_addr,
                 o_mem_wrdata, {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, e_addr);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (o_ldst_rddata !== 16'h1234 || wr_cnt != 1)
      $display("FAIL wr_rd_data got d=%h wr_cycles=%0d required d=1234 wr_cycles=1", o_ldst_rddata, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    for (int a = 0; a < 8; a++) begin ram[a] = 16'(16'hA000 + a * 3); m_mem[a] = ram[a]; end
    for (int k = 0; k < 8 + RD_LAT + 3; k++) begin
      drive(k < 8, 16'(k), 1'b0, 1'b0, 16'h0000, 16'h0000);
      if (o_pc_valid === 1'b1) begin
        n_chk++;
        if (k != nv + RD_LAT + 1 || o_pc_rddata !== 16'(16'hA000 + nv * 3))
          $display("FAIL b2b_data cyc=%0d got=%h required=%h at cyc %0d", k, o_pc_rddata,
                   16'(16'hA000 + nv * 3), nv + RD_LAT + 1);
        else n_pass++;
        nv++;
      end
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_mem_addr}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, e_addr})
        $display("FAIL b2b_ctl cyc=%0d got=%b_%h required=%b_%h", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_mem_addr,
                 {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, e_addr);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (nv != 8) $display("FAIL b2b_count got %0d valids required 8", nv);
    else n_pass++;
  endtask

  task automatic test_proto();
    for (int k = 0; k < RD_LAT + 4; k++) begin
      drive(1'b0, 16'h0000, k == 0, k == 0, 16'h0030, 16'h5555);
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_mem_addr}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, e_addr})
        $display("FAIL proto_ctl cyc=%0d got=%b_%h required=%b_%h", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_mem_addr,
                 {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, e_addr);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (o_proto_err !== 1'b1 || ram[16'h0030] !== 16'h5555)
      $display("FAIL proto_sticky got err=%b ram=%h required err=1 ram=5555", o_proto_err, ram[16'h0030]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic pp = 1'b0, lp = 1'b0, lw = 1'b0;
    logic [AW-1:0] pa = '0, la = '0;
    logic [DW-1:0] wd = '0;
    for (int k = 0; k < 400; k++) begin
      if (!pp && k < 390 && $urandom_range(1, 0) == 1) begin pp = 1'b1; pa = 16'($urandom_range(15, 0)); end
      if (!lp && k < 390 && $urandom_range(2, 0) != 0) begin
        lp = 1'b1; lw = 1'($urandom_range(1, 0)); la = 16'($urandom_range(15, 0)); wd = 16'($urandom);
      end
      drive(pp, pa, lp && !lw, lp && lw, la, wd);
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_mem_addr}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, e_addr})
        $display("FAIL rand_ctl cyc=%0d got=%b_%h required=%b_%h", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_mem_addr,
                 {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, e_addr);
      else n_pass++;
      n_chk++;
      if ({o_pc_rddata, o_ldst_rddata} !== {m_pc_d, m_l_d})
        $display("FAIL rand_data cyc=%0d got=%h/%h required=%h/%h", k, o_pc_rddata, o_ldst_rddata, m_pc_d, m_l_d);
      else n_pass++;
      if (e_pg) pp = 1'b0;
      if (e_lg) lp = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    ram[16'h0040] = 16'h7777; m_mem[16'h0040] = 16'h7777;
    drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    drive(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000, 16'h0000);
    reset = 1'b0;
    q.delete(); m_pc_d = '0; m_l_d = '0; m_wait = 0; m_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err,
           o_pc_rddata, o_ldst_rddata} !== '0)
        $display("FAIL midflight_reset k=%0d got gnt=%b rd=%b v=%b%b err=%b d=%h/%h required all 0", k,
                 o_pc_gnt, o_mem_rd, o_pc_valid, o_ldst_valid, o_proto_err, o_pc_rddata, o_ldst_rddata);
      else n_pass++;
      @(negedge clk);
    end
    reset = 1'b1;
    for (int k = 0; k < RD_LAT + 4; k++) begin
      drive(k == 0, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000);
      n_chk++;
      if ({o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err, o_pc_rddata}
          !== {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err, m_pc_d})
        $display("FAIL post_reset_read cyc=%0d got=%b_%h required=%b_%h", k,
                 {o_pc_gnt, o_ldst_gnt, o_mem_rd, o_mem_wr, o_pc_valid, o_ldst_valid, o_proto_err}, o_pc_rddata,
                 {e_pg, e_lg, e_mr, e_mw, e_pv, e_lv, m_err}, m_pc_d);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (o_pc_rddata !== 16'h7777) $display("FAIL post_reset_data got=%h required=7777", o_pc_rddata);
    else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin ram[a] = 16'($urandom); m_mem[a] = ram[a]; end
    test_reset();
    test_pc_single();
    test_starve();
    test_write_read();
    test_back_to_back();
    test_proto();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
